// File: rtl/axi4_slave_mem.sv
// axi4_slave_mem: AXI4 responder backed by an internal word-addressed SRAM model.
//
// Write and read paths are independent FSMs that run concurrently. The slave
// supports FIXED, INCR and WRAP bursts of 1-16 beats, byte strobes, and
// OKAY/SLVERR responses. All outputs are registered. The memory contents are
// not reset.
//
// Ports:
//   clk, rst                              clock (rising edge), async active-high reset
//   AWID/AWADDR/AWLEN/AWSIZE/AWBURST      write address fields
//   AWVALID/AWREADY                       write address handshake
//   WID/WDATA/WSTRB/WLAST                 write data fields
//   WVALID/WREADY                         write data handshake
//   BID/BRESP, BVALID/BREADY              write response and handshake
//   ARID/ARADDR/ARLEN/ARSIZE/ARBURST      read address fields
//   ARVALID/ARREADY                       read address handshake
//   RID/RDATA/RRESP/RLAST                 read data fields
//   RVALID/RREADY                         read data handshake
module axi4_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int ID_WIDTH   = 9
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [3:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,

    input  logic [ID_WIDTH-1:0]     WID,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,

    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,

    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [3:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,

    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] LIMIT    = (ADDR_WIDTH + 1)'(MEM_DEPTH * BYTES);
    localparam logic [2:0]          MAX_SIZE = 3'(LSB);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Address of the beat following 'a' for the given burst parameters.
    function automatic logic [ADDR_WIDTH-1:0] step(input logic [ADDR_WIDTH-1:0] a,
                                                   input logic [2:0]            sz,
                                                   input logic [3:0]            len,
                                                   input logic [1:0]            burst);
        logic [ADDR_WIDTH-1:0] s;
        logic [ADDR_WIDTH-1:0] b;
        s = ADDR_WIDTH'(1) << sz;
        b = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) * s;
        case (burst)
            2'b01:   step = a + s;
            2'b10:   step = (a & ~(b - ADDR_WIDTH'(1))) | ((a + s) & (b - ADDR_WIDTH'(1)));
            default: step = a;
        endcase
    endfunction

    // Burst-level errors, fixed for the whole transaction once the address is accepted.
    function automatic logic cfg_bad(input logic [ADDR_WIDTH-1:0] a,
                                     input logic [2:0]            sz,
                                     input logic [3:0]            len,
                                     input logic [1:0]            burst);
        logic [ADDR_WIDTH-1:0] s;
        logic                  wrap_bad;
        s        = ADDR_WIDTH'(1) << sz;
        wrap_bad = (burst == 2'b10) &&
                   (!(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15) ||
                    ((a & (s - ADDR_WIDTH'(1))) != '0));
        cfg_bad  = (sz > MAX_SIZE) || (burst == 2'b11) || wrap_bad;
    endfunction

    function automatic logic oor(input logic [ADDR_WIDTH-1:0] a);
        oor = {1'b0, a} >= LIMIT;
    endfunction

    function automatic logic [IDX_W-1:0] widx(input logic [ADDR_WIDTH-1:0] a);
        widx = a[LSB +: IDX_W];
    endfunction

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

    wstate_t               w_state, w_next;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [3:0]            w_len, w_cnt;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic                  w_cfg_err, w_err;
    logic                  aw_fire, w_fire, b_fire, w_last_beat, w_beat_err;

    always_comb begin
        aw_fire     = AWREADY && AWVALID;
        w_fire      = WREADY && WVALID;
        b_fire      = BVALID && BREADY;
        w_last_beat = (w_cnt == w_len);
        w_beat_err  = w_cfg_err || oor(w_addr) || (WID != w_id) || (WLAST != w_last_beat);
        w_next      = w_state;
        case (w_state)
            W_IDLE:  if (aw_fire)               w_next = W_DATA;
            W_DATA:  if (w_fire && w_last_beat) w_next = W_RESP;
            W_RESP:  if (b_fire)                w_next = W_IDLE;
            default:                            w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    // Ready/valid flags are registered copies of the next-state decode so they
    // stay low while reset is held and rise one edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            AWREADY   <= 1'b0;
            WREADY    <= 1'b0;
            BVALID    <= 1'b0;
            BID       <= '0;
            BRESP     <= '0;
            w_id      <= '0;
            w_addr    <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            w_size    <= '0;
            w_burst   <= '0;
            w_cfg_err <= 1'b0;
            w_err     <= 1'b0;
        end else begin
            AWREADY <= (w_next == W_IDLE);
            WREADY  <= (w_next == W_DATA);
            BVALID  <= (w_next == W_RESP);
            if (aw_fire) begin
                w_id      <= AWID;
                w_addr    <= AWADDR;
                w_len     <= AWLEN;
                w_size    <= AWSIZE;
                w_burst   <= AWBURST;
                w_cfg_err <= cfg_bad(AWADDR, AWSIZE, AWLEN, AWBURST);
                w_err     <= 1'b0;
                w_cnt     <= '0;
            end
            if (w_fire) begin
                w_addr <= step(w_addr, w_size, w_len, w_burst);
                w_cnt  <= w_cnt + 4'd1;
                if (w_beat_err) w_err <= 1'b1;
                if (w_last_beat) begin
                    BID   <= w_id;
                    BRESP <= (w_err || w_beat_err) ? 2'b10 : 2'b00;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire && !w_beat_err) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (WSTRB[i]) mem[widx(w_addr)][8*i +: 8] <= WDATA[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    rstate_t               r_state, r_next;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_len, r_cnt;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_cfg_err;
    logic                  ar_fire, r_fire, r_present, r_beat_err;

    // r_addr/r_cnt always describe the next beat to be presented. A beat is
    // loaded when the R register is empty or its current beat is being
    // accepted and more remain, which gives one beat per cycle under RREADY=1.
    always_comb begin
        ar_fire    = ARREADY && ARVALID;
        r_fire     = RVALID && RREADY;
        r_present  = (r_state == R_DATA) && (!RVALID || (RREADY && !RLAST));
        r_beat_err = r_cfg_err || oor(r_addr);
        r_next     = r_state;
        case (r_state)
            R_IDLE:  if (ar_fire)          r_next = R_DATA;
            R_DATA:  if (r_fire && RLAST)  r_next = R_IDLE;
            default:                       r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ARREADY   <= 1'b0;
            RVALID    <= 1'b0;
            RLAST     <= 1'b0;
            RID       <= '0;
            RDATA     <= '0;
            RRESP     <= '0;
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            ARREADY <= (r_next == R_IDLE);
            if (ar_fire) begin
                r_id      <= ARID;
                r_addr    <= ARADDR;
                r_len     <= ARLEN;
                r_size    <= ARSIZE;
                r_burst   <= ARBURST;
                r_cfg_err <= cfg_bad(ARADDR, ARSIZE, ARLEN, ARBURST);
                r_cnt     <= '0;
            end
            if (r_present) begin
                RVALID <= 1'b1;
                RID    <= r_id;
                RDATA  <= r_beat_err ? '0 : mem[widx(r_addr)];
                RRESP  <= r_beat_err ? 2'b10 : 2'b00;
                RLAST  <= (r_cnt == r_len);
                r_addr <= step(r_addr, r_size, r_len, r_burst);
                r_cnt  <= r_cnt + 4'd1;
            end else if (r_fire) begin
                RVALID <= 1'b0;
                RLAST  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/axi4_slave_mem.md
Name: axi4_slave_mem

Overview:
AXI4 responder (slave) with an internal word-addressed SRAM model. It is the RTL endpoint that the master-side agents drive, and it answers all five AXI4 channels. Write and read paths are independent FSMs. It supports FIXED, INCR and WRAP bursts of 1–16 beats, byte strobes, and OKAY/SLVERR responses.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data bus width in bits (power of 2, ≥16)
MEM_DEPTH, 1024, memory size in DATA_WIDTH words; addresses at or beyond MEM_DEPTH*(DATA_WIDTH/8) are out of range
ID_WIDTH, 9, transaction ID width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_WIDTH/ADDR_WIDTH/4/3/2  write address fields
AWVALID in 1, AWREADY out 1  write address handshake
WID/WDATA/WSTRB/WLAST  in  ID_WIDTH/DATA_WIDTH/DATA_WIDTH/8/1  write data fields
WVALID in 1, WREADY out 1  write data handshake
BID/BRESP  out  ID_WIDTH/2  write response
BVALID out 1, BREADY in 1  write response handshake
ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID_WIDTH/ADDR_WIDTH/4/3/2  read address fields
ARVALID in 1, ARREADY out 1  read address handshake
RID/RDATA/RRESP/RLAST  out  ID_WIDTH/DATA_WIDTH/2/1  read data fields
RVALID out 1, RREADY in 1  read data handshake

Behaviour:
- Reset (async assert): both FSMs go to IDLE. All outputs are 0. Memory contents are retained and not cleared. Asserting rst mid-burst abandons the burst with no response.
- Transfer rule: a transfer occurs on a rising clk edge with VALID&&READY. Outputs are registered, and no output depends combinationally on an input.
- Write FSM (W_IDLE → W_DATA → W_RESP):
  - W_IDLE: AWREADY=1. On AW handshake, latch ID, addr, len, size and burst; clear err and beat count; move to W_DATA. AWREADY drops the next cycle.
  - W_DATA: WREADY=1. On each beat, write the byte lanes whose WSTRB bit is set into mem[addr>>log2(DATA_WIDTH/8)], then advance the address and beat count.
  - Exit to W_RESP is decided by beat count == len+1, not by WLAST.
  - W_RESP: BVALID=1, BID=latched AWID. BRESP=2'b10 (SLVERR) if err, else 2'b00. Hold all values until BREADY, then return to W_IDLE.
  - err is set, and the memory write suppressed, when any of these holds:
    - beat address out of range;
    - AWSIZE > log2(DATA_WIDTH/8);
    - WID ≠ latched AWID;
    - WLAST ≠ (beat == last);
    - AWBURST == 2'b11;
    - illegal WRAP.
  - A back-to-back AW is accepted no earlier than the cycle after the B handshake.
- Read FSM (R_IDLE → R_DATA):
  - R_IDLE: ARREADY=1. On AR handshake, latch fields and move to R_DATA. The first RVALID rises on the next edge (latency 1 cycle from the AR handshake).
  - R_DATA: RID=latched ARID. RDATA=mem word, or 0 on error. RRESP per beat uses the same error rules as writes, excluding WID/WLAST. RLAST=1 only on beat len.
  - While RVALID && !RREADY, all R outputs hold stable.
  - On a handshake of a non-last beat, the next beat is presented on the following edge (full throughput with RREADY held high).
  - After the last handshake, RVALID=0 and the FSM returns to R_IDLE.
- Address generation (size bytes S=1<<size):
  - FIXED: address constant.
  - INCR: addr += S, with no 4KB check.
  - WRAP: len must be 1, 3, 7 or 15 and the start address aligned to S, else err. Boundary B=(len+1)*S. Next = (addr & ~(B-1)) | ((addr+S) & (B-1)).
- Concurrency: read and write paths run simultaneously. A same-cycle read and write to one word returns the old data (read-first). Bytes with WSTRB=0 are unchanged.

Test Plan:
- Reset then single write: AW{id=5, addr=0x10, len=0, size=2, INCR}, W{data=0xDEADBEEF, strb=F, last=1}, BREADY=1 → BVALID within 3 cycles of AW, BID=5, BRESP=00. Then read AR{id=7, addr=0x10} → RVALID 1 cycle after AR handshake, RDATA=0xDEADBEEF, RID=7, RLAST=1, RRESP=00.
- INCR burst len=3 from 0x100, data 1..4, then read back with RREADY toggling every other cycle → RDATA 1,2,3,4 in order, each held stable while RREADY=0, RLAST only on the 4th beat.
- WRAP len=3 size=2 starting at 0x28 → beats land at 0x28, 0x2C, 0x20, 0x24. Read INCR from 0x20 len=3 returns beats 3, 4, 1, 2.
- Strobe and error: write 0x11223344 strb=4'b0101 over 0xFFFFFFFF → read 0xFF22FF44. Write to addr 4*MEM_DEPTH → BRESP=10 and memory unchanged. Read there → RRESP=10, RDATA=0.
- Protocol errors: WID≠AWID, or WLAST asserted early on beat 1 of len=3 → BRESP=10, still exactly 4 beats accepted. AWSIZE=3 with DATA_WIDTH=32 → BRESP=10.
- Assert rst mid read burst (beat 2 of 8) → RVALID=0 and ARREADY=0 during reset, ARREADY=1 one cycle after release. A new read returns correct data, and prior memory contents are intact.
